// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared stall/state encodings and control constants for the pipeline controller
package pipeline_ctrl_pkg;
  localparam logic RESET_ENABLE = 1'b1;
  localparam logic STALL_ENABLE = 1'b1;
  localparam logic STALL_DISABLE = 1'b0;
  localparam logic WRITE_ENABLE = 1'b1;
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_FROM_ID = 6'b000111;
  localparam logic [5:0] STALL_FROM_EX = 6'b001111;
  localparam logic [5:0] STALL_FROM_MEM = 6'b011111;
  typedef enum logic {CTRL_RUN, CTRL_FLUSH} ctrl_state_e;
endpackage

// File: rtl/pipeline_redirect_buf.sv
// pipeline_redirect_buf: holds one branch redirect that arrived while the PC was frozen and replays it when the PC unfreezes
module pipeline_redirect_buf
  import pipeline_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        clear,
  input  logic        hold,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        pc_write_enable,
  output logic [31:0] pc_write_data
);
  logic        pending_valid_q, pending_valid_d;
  logic [31:0] pending_target_q, pending_target_d;
  // Drain the buffered redirect first; a new redirect while one is buffered is dropped
  always_comb begin
    pending_valid_d = pending_valid_q;
    pending_target_d = pending_target_q;
    pc_write_enable = ~WRITE_ENABLE;
    pc_write_data = '0;
    if (clear) begin
      pending_valid_d = 1'b0;
    end else if (enable && hold == STALL_DISABLE) begin
      pc_write_enable = pending_valid_q || redirect_valid;
      pc_write_data = pending_valid_q ? pending_target_q : redirect_valid ? redirect_target : '0;
      pending_valid_d = 1'b0;
    end else if (enable && redirect_valid && !pending_valid_q) begin
      pending_valid_d = 1'b1;
      pending_target_d = redirect_target;
    end
  end
  // Pending redirect register
  always_ff @(posedge clock) begin
    if (reset == RESET_ENABLE) begin
      pending_valid_q <= 1'b0;
      pending_target_q <= '0;
    end else begin
      pending_valid_q <= pending_valid_d;
      pending_target_q <= pending_target_d;
    end
  end
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall merge, redirect/exception arbitration and post-exception flush sequencing; STALL_WATCHDOG_EN adds a sticky stall watchdog
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int WATCHDOG_LIMIT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        exception_valid,
  input  logic [31:0] exception_vector,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] pc_write_data,
  output logic        pc_write_enable,
  output logic        stall_timeout
);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  if (FLUSH_CYCLES < 1 || WATCHDOG_LIMIT < 1) begin : g_bad_param
    $error("pipeline_ctrl: FLUSH_CYCLES and WATCHDOG_LIMIT must be >= 1");
  end
  ctrl_state_e state_q, state_d;
  logic [FW-1:0] cnt_q, cnt_d;
  logic [5:0] stall_req;
  logic run_exc, buf_we;
  logic [31:0] buf_data;
  assign run_exc = reset != RESET_ENABLE && state_q == CTRL_RUN && exception_valid;
  assign flush = reset != RESET_ENABLE && (state_q == CTRL_FLUSH || run_exc);
  // Most downstream stall request wins; nothing is held while resetting or flushing
  always_comb begin
    stall_req = reset == RESET_ENABLE ? STALL_NONE :
                stallreq_mem ? STALL_FROM_MEM :
                stallreq_ex ? STALL_FROM_EX :
                stallreq_id ? STALL_FROM_ID : STALL_NONE;
    stall = flush ? STALL_NONE : stall_req;
  end
  pipeline_redirect_buf u_redirect_buf (
    .clock           (clock),
    .reset           (reset),
    .enable          (reset != RESET_ENABLE && state_q == CTRL_RUN && !exception_valid),
    .clear           (run_exc),
    .hold            (stall[0]),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .pc_write_enable (buf_we),
    .pc_write_data   (buf_data)
  );
  assign pc_write_enable = run_exc || buf_we;
  assign pc_write_data = run_exc ? exception_vector : buf_data;
  // Exception enters FLUSH for the remaining drain cycles; counter at 1 returns to RUN
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (run_exc && FLUSH_CYCLES > 1) begin
      state_d = CTRL_FLUSH;
      cnt_d = FW'(FLUSH_CYCLES - 1);
    end else if (state_q == CTRL_FLUSH) begin
      cnt_d = cnt_q - 1'b1;
      state_d = cnt_q == FW'(1) ? CTRL_RUN : CTRL_FLUSH;
    end
  end
  // Controller state register
  always_ff @(posedge clock) begin
    if (reset == RESET_ENABLE) begin
      state_q <= CTRL_RUN;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
`ifdef STALL_WATCHDOG_EN
  localparam int WW = $clog2(WATCHDOG_LIMIT + 1);
  logic [WW-1:0] wd_q, wd_d;
  logic timeout_q, timeout_d;
  // Count consecutive PC-frozen cycles in RUN, saturating at the limit; the flag is sticky
  always_comb begin
    wd_d = (stall[0] != STALL_ENABLE || flush || state_q != CTRL_RUN) ? '0 :
           wd_q == WW'(WATCHDOG_LIMIT) ? wd_q : wd_q + 1'b1;
    timeout_d = timeout_q || wd_d == WW'(WATCHDOG_LIMIT);
  end
  // Watchdog registers
  always_ff @(posedge clock) begin
    if (reset == RESET_ENABLE) begin
      wd_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      timeout_q <= timeout_d;
    end
  end
  assign stall_timeout = timeout_q && reset != RESET_ENABLE;
`else
  assign stall_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed scoreboard bench for pipeline_ctrl
module tb_pipeline_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic stallreq_id = 1'b0, stallreq_ex = 1'b0, stallreq_mem = 1'b0;
  logic redirect_valid = 1'b0, exception_valid = 1'b0;
  logic [31:0] redirect_target = '0, exception_vector = '0;
  logic [5:0] stall;
  logic flush, pc_write_enable, stall_timeout;
  logic [31:0] pc_write_data;
  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic        we;
    logic [31:0] data;
    logic        to;
    string       name;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  localparam logic [5:0] S0 = 6'b000000, SI = 6'b000111, SE = 6'b001111, SM = 6'b011111;

  pipeline_ctrl #(.FLUSH_CYCLES(2), .WATCHDOG_LIMIT(4)) dut (
    .clock            (clock),
    .reset            (reset),
    .stallreq_id      (stallreq_id),
    .stallreq_ex      (stallreq_ex),
    .stallreq_mem     (stallreq_mem),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .exception_valid  (exception_valid),
    .exception_vector (exception_vector),
    .stall            (stall),
    .flush            (flush),
    .pc_write_data    (pc_write_data),
    .pc_write_enable  (pc_write_enable),
    .stall_timeout    (stall_timeout)
  );

  always #5 clock = ~clock;

  task automatic step(input logic r, m, e, i, v, input logic [31:0] t, input logic x,
                      input logic [31:0] xv, input logic [5:0] s, input logic f, w,
                      input logic [31:0] d, input logic o, input string n);
    @(negedge clock);
    reset = r;
    stallreq_mem = m;
    stallreq_ex = e;
    stallreq_id = i;
    redirect_valid = v;
    redirect_target = t;
    exception_valid = x;
    exception_vector = xv;
    sb.push_back('{s, f, w, d, o, n});
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ({stall, flush, pc_write_enable, pc_write_data, stall_timeout} !==
            {e.stall, e.flush, e.we, e.data, e.to}) begin
          failures++;
          $display("FAIL %s: got stall=%b flush=%b we=%b data=%h timeout=%b, expected stall=%b flush=%b we=%b data=%h timeout=%b",
                   e.name, stall, flush, pc_write_enable, pc_write_data, stall_timeout,
                   e.stall, e.flush, e.we, e.data, e.to);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish within 200000");
    $fatal(1, "timeout");
  end

  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0, S0, 0, 0, 0, 0, "reset1");
    step(1, 1, 0, 0, 1, 32'h1234, 1, 32'h80000180, S0, 0, 0, 0, 0, "reset2_busy");
    step(0, 0, 0, 0, 0, 0, 0, 0, S0, 0, 0, 0, 0, "idle1");
    step(0, 0, 0, 0, 0, 0, 0, 0, S0, 0, 0, 0, 0, "idle2");
    step(0, 0, 1, 1, 0, 0, 0, 0, SE, 0, 0, 0, 0, "ex_id");
    step(0, 1, 1, 1, 0, 0, 0, 0, SM, 0, 0, 0, 0, "mem_ex_id");
    step(0, 0, 0, 1, 0, 0, 0, 0, SI, 0, 0, 0, 0, "id_only");
    step(0, 0, 0, 0, 1, 32'h00400100, 0, 0, S0, 0, 1, 32'h00400100, 0, "redir_direct");
    step(0, 0, 0, 0, 0, 0, 0, 0, S0, 0, 0, 0, 0, "after_redir");
    step(0, 1, 0, 0, 1, 32'h00400020, 0, 0, SM, 0, 0, 0, 0, "stall_redir1");
    step(0, 1, 0, 0, 0, 0, 0, 0, SM, 0, 0, 0, 0, "stall2");
    step(0, 1, 0, 0, 0, 0, 0, 0, SM, 0, 0, 0, 0, "stall3");
    step(0, 0, 0, 0, 0, 0, 0, 0, S0, 0, 1, 32'h00400020, 0, "drain");
    step(0, 0, 0, 0, 0, 0, 0, 0, S0, 0, 0, 0, 0, "post_drain");
    step(0, 1, 0, 0, 1, 32'h00001000, 0, 0, SM, 0, 0, 0, 0, "cap_first");
    step(0, 1, 0, 0, 1, 32'h00002000, 0, 0, SM, 0, 0, 0, 0, "viol_kept_first");
    step(0, 0, 0, 0, 1, 32'h00003000, 0, 0, S0, 0, 1, 32'h00001000, 0, "drain_first");
    step(0, 0, 0, 0, 0, 0, 0, 0, S0, 0, 0, 0, 0, "post_viol");
    step(0, 1, 0, 0, 1, 32'h00400040, 0, 0, SM, 0, 0, 0, 0, "pend_pre_exc");
    step(0, 1, 0, 0, 1, 32'h00005555, 1, 32'h80000180, S0, 1, 1, 32'h80000180, 0, "exc");
    step(0, 1, 0, 0, 1, 32'h00006666, 1, 32'h12345678, S0, 1, 0, 0, 0, "flush2_ignored");
    step(0, 1, 0, 0, 0, 0, 0, 0, SM, 0, 0, 0, 0, "post_flush_stall");
    step(0, 0, 0, 0, 0, 0, 0, 0, S0, 0, 0, 0, 0, "pend_never_issued");
    step(0, 0, 0, 0, 0, 0, 1, 32'hBFC00380, S0, 1, 1, 32'hBFC00380, 0, "exc_a");
    step(0, 0, 0, 0, 0, 0, 1, 32'hBFC00380, S0, 1, 0, 0, 0, "exc_a_flush");
    step(0, 0, 0, 0, 0, 0, 1, 32'hBFC00380, S0, 1, 1, 32'hBFC00380, 0, "exc_b");
    step(0, 0, 0, 0, 0, 0, 0, 0, S0, 1, 0, 0, 0, "exc_b_flush");
    step(0, 0, 0, 0, 0, 0, 0, 0, S0, 0, 0, 0, 0, "exc_done");
    step(0, 1, 0, 0, 1, 32'h00007000, 0, 0, SM, 0, 0, 0, 0, "pend_rst");
    step(1, 0, 0, 0, 0, 0, 0, 0, S0, 0, 0, 0, 0, "rst_mid_pend");
    step(0, 0, 0, 0, 0, 0, 0, 0, S0, 0, 0, 0, 0, "pend_lost");
    step(0, 0, 0, 0, 0, 0, 1, 32'h80000080, S0, 1, 1, 32'h80000080, 0, "exc_c");
    step(1, 0, 0, 0, 0, 0, 0, 0, S0, 0, 0, 0, 0, "rst_mid_flush");
    step(0, 0, 0, 0, 0, 0, 0, 0, S0, 0, 0, 0, 0, "flush_cleared");
`ifdef STALL_WATCHDOG_EN
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 0, 0, 0, 0, SI, 0, 0, 0, 0, "wd3_stall");
    step(0, 0, 0, 0, 0, 0, 0, 0, S0, 0, 0, 0, 0, "wd3_never_set");
    for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 0, 0, 0, 0, SI, 0, 0, 0, 0, "wd4_stall");
    step(0, 0, 0, 0, 0, 0, 0, 0, S0, 0, 0, 0, 1, "wd_set");
    step(0, 0, 0, 0, 0, 0, 0, 0, S0, 0, 0, 0, 1, "wd_sticky");
    step(1, 0, 0, 0, 0, 0, 0, 0, S0, 0, 0, 0, 0, "wd_reset");
    step(0, 0, 0, 0, 0, 0, 0, 0, S0, 0, 0, 0, 0, "wd_cleared");
`endif
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clock);
    #3;
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain_scoreboard: got %0d unchecked entries, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
